vga_text_scroll_engine: RTL and testbench



---
 rtl/vga_text_scroll_engine_if.sv | 45 ++++
 rtl/vga_text_scroll_engine.sv | 186 ++++++++++++++++++
 tb/tb_vga_text_scroll_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_scroll_engine_if.sv
// Port bundle for vga_text_scroll_engine: CPU access port, command handshake
// and the io port toward vga_driver.
interface vga_text_scroll_engine_if;
  // cmd handshake: a command transfers at a rising edge where cmd_valid && cmd_ready;
  // cmd_* must be stable in that cycle; cmd_ready is high only in IDLE.
  logic        cpu_do_write;
  logic        cpu_do_byte_op;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_write_data;
  logic [15:0] cpu_read_data;
  logic        cpu_stall;

  logic        cmd_valid;
  logic        cmd_op;
  logic [7:0]  cmd_char;
  logic [7:0]  cmd_fg;
  logic [7:0]  cmd_bg;
  logic        cmd_ready;
  logic        busy;
  logic        done;

  logic        io_do_write;
  logic        io_do_byte_op;
  logic [14:0] io_addr;
  logic [15:0] io_write_data;
  logic [15:0] io_read_data;

  modport slave (
    input  cpu_do_write, cpu_do_byte_op, cpu_addr, cpu_write_data,
    output cpu_read_data, cpu_stall,
    input  cmd_valid, cmd_op, cmd_char, cmd_fg, cmd_bg,
    output cmd_ready, busy, done,
    output io_do_write, io_do_byte_op, io_addr, io_write_data,
    input  io_read_data
  );

  modport master (
    output cpu_do_write, cpu_do_byte_op, cpu_addr, cpu_write_data,
    input  cpu_read_data, cpu_stall,
    output cmd_valid, cmd_op, cmd_char, cmd_fg, cmd_bg,
    input  cmd_ready, busy, done,
    input  io_do_write, io_do_byte_op, io_addr, io_write_data,
    output io_read_data
  );
endinterface

// File: rtl/vga_text_scroll_engine.sv
// Scroll-up / clear engine in front of the VGA text buffer io port.
// Define VGA_TEXT_CLEAR_EN to build the full-screen clear; otherwise cmd_op=1 completes as a no-op.
module vga_text_scroll_engine #(
  parameter int BASE   = 0,
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int RD_LAT = 2
) (
  input  logic                      main_clk,
  input  logic                      main_rst_n,
  vga_text_scroll_engine_if.slave   bus,
  output logic [2:0]                dbg_state_o
);

  localparam int ROW_BYTES  = COLS * 3;
  localparam int COPY_WORDS = (ROWS - 1) * COLS * 3 / 2;
  localparam int ROW_WORDS  = COLS * 3 / 2;

  localparam logic [14:0] SRC_BASE  = 15'(BASE + ROW_BYTES);
  localparam logic [14:0] DST_BASE  = 15'(BASE);
  localparam logic [14:0] LAST_ROW  = 15'(BASE + (ROWS - 1) * ROW_BYTES);
  localparam logic [14:0] COPY_LAST = 15'(COPY_WORDS - 1);
  localparam logic [14:0] ROW_LAST  = 15'(ROW_WORDS - 1);
  localparam logic [7:0]  WAIT_LAST = 8'((RD_LAT > 1) ? RD_LAT - 2 : 0);
`ifdef VGA_TEXT_CLEAR_EN
  localparam logic [14:0] ALL_LAST  = 15'(ROWS * COLS * 3 / 2 - 1);
`endif

  // Keep the mode, font-base and frame-counter bytes above 20476 out of reach.
  if (BASE % 2 != 0) begin : g_bad_base
    $error("vga_text_scroll_engine: BASE must be even");
  end
  if (BASE + ROWS * COLS * 3 > 20476) begin : g_bad_size
    $error("vga_text_scroll_engine: text area overlaps control bytes");
  end
  if ((COLS * 3) % 2 != 0) begin : g_bad_cols
    $error("vga_text_scroll_engine: COLS*3 must be even");
  end
  if (RD_LAT < 1) begin : g_bad_lat
    $error("vga_text_scroll_engine: RD_LAT must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_FILL, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic [14:0] fill_base_q, fill_base_d;
  logic [14:0] fill_last_q, fill_last_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  char_q, char_d, fg_q, fg_d, bg_q, bg_d;

  logic [14:0] word_off;
  logic [1:0]  phase_p1, phase_p2;

  function automatic logic [7:0] pick(input logic [1:0] ph, input logic [7:0] c,
                                      input logic [7:0] f, input logic [7:0] b);
    case (ph)
      2'd0:    pick = c;
      2'd1:    pick = f;
      default: pick = b;
    endcase
  endfunction

  assign word_off = {cnt_q[13:0], 1'b0};
  // Byte phase of the high byte of this word, and of the next word's low byte.
  assign phase_p1 = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
  assign phase_p2 = (phase_p1 == 2'd2) ? 2'd0 : phase_p1 + 2'd1;

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.cpu_stall     = (state_q != S_IDLE);
  assign bus.cpu_read_data = bus.io_read_data;
  assign dbg_state_o       = state_q;

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    wait_d            = wait_q;
    fill_base_d       = fill_base_q;
    fill_last_d       = fill_last_q;
    phase_d           = phase_q;
    char_d            = char_q;
    fg_d              = fg_q;
    bg_d              = bg_q;
    bus.io_do_write   = 1'b0;
    bus.io_do_byte_op = 1'b0;
    bus.io_addr       = 15'd0;
    bus.io_write_data = 16'd0;
    bus.cmd_ready     = 1'b0;
    bus.done          = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Gated by reset so the io port and cmd_ready sit at zero while held in reset.
        if (main_rst_n) begin
          bus.io_do_write   = bus.cpu_do_write;
          bus.io_do_byte_op = bus.cpu_do_byte_op;
          bus.io_addr       = bus.cpu_addr;
          bus.io_write_data = bus.cpu_write_data;
          bus.cmd_ready     = 1'b1;
        end
        if (bus.cmd_valid) begin
          char_d  = bus.cmd_char;
          fg_d    = bus.cmd_fg;
          bg_d    = bus.cmd_bg;
          cnt_d   = 15'd0;
          phase_d = 2'd0;
          if (!bus.cmd_op) begin
            fill_base_d = LAST_ROW;
            fill_last_d = ROW_LAST;
            state_d     = (COPY_WORDS > 0) ? S_RD : S_FILL;
          end else begin
`ifdef VGA_TEXT_CLEAR_EN
            fill_base_d = DST_BASE;
            fill_last_d = ALL_LAST;
            state_d     = S_FILL;
`else
            state_d     = S_DONE;
`endif
          end
        end
      end
      S_RD: begin
        bus.io_addr = SRC_BASE + word_off;
        wait_d      = 8'd0;
        state_d     = (RD_LAT > 1) ? S_WAIT : S_WR;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_WR;
        else                     wait_d  = wait_q + 8'd1;
      end
      S_WR: begin
        bus.io_do_write   = 1'b1;
        bus.io_addr       = DST_BASE + word_off;
        bus.io_write_data = bus.io_read_data;
        if (cnt_q == COPY_LAST) begin
          cnt_d   = 15'd0;
          phase_d = 2'd0;
          state_d = S_FILL;
        end else begin
          cnt_d   = cnt_q + 15'd1;
          state_d = S_RD;
        end
      end
      S_FILL: begin
        bus.io_do_write   = 1'b1;
        bus.io_addr       = fill_base_q + word_off;
        bus.io_write_data = {pick(phase_p1, char_q, fg_q, bg_q),
                             pick(phase_q, char_q, fg_q, bg_q)};
        phase_d           = phase_p2;
        if (cnt_q == fill_last_q) state_d = S_DONE;
        else                      cnt_d   = cnt_q + 15'd1;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 15'd0;
      wait_q      <= 8'd0;
      fill_base_q <= 15'd0;
      fill_last_q <= 15'd0;
      phase_q     <= 2'd0;
      char_q      <= 8'd0;
      fg_q        <= 8'd0;
      bg_q        <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      fill_base_q <= fill_base_d;
      fill_last_q <= fill_last_d;
      phase_q     <= phase_d;
      char_q      <= char_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
    end
  end

endmodule

// File: tb/tb_vga_text_scroll_engine.sv
// Directed bench for vga_text_scroll_engine with a byte-array model of the vga_driver
// io port (2-cycle read latency, little-endian words).
module tb_vga_text_scroll_engine;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  logic       preload;
  int         n_checks;
  int         n_errors;
  int         eng_wr_cnt;
  int         bad_op_cnt;

  logic [7:0]  mem [0:32767];
  logic [15:0] rd_p0, rd_p1;

  vga_text_scroll_engine_if bus();

  vga_text_scroll_engine dut (
    .main_clk    (clk),
    .main_rst_n  (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  assign bus.io_read_data = rd_p1;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32768; i += 2) begin
        mem[i]     <= 8'(i);
        mem[i + 1] <= 8'(i >> 8);
      end
    end else if (bus.io_do_write) begin
      if (bus.io_do_byte_op) begin
        mem[bus.io_addr] <= bus.io_write_data[7:0];
      end else begin
        mem[{bus.io_addr[14:1], 1'b0}] <= bus.io_write_data[7:0];
        mem[{bus.io_addr[14:1], 1'b1}] <= bus.io_write_data[15:8];
      end
    end
    rd_p0 <= {mem[{bus.io_addr[14:1], 1'b1}], mem[{bus.io_addr[14:1], 1'b0}]};
    rd_p1 <= rd_p0;
  end

  always @(negedge clk) begin
    if (bus.busy && bus.io_do_write) eng_wr_cnt <= eng_wr_cnt + 1;
    if (bus.busy && bus.io_do_write && (bus.io_do_byte_op || bus.io_addr[0]))
      bad_op_cnt <= bad_op_cnt + 1;
  end

  function automatic logic [15:0] rdw(input int a);
    rdw = {mem[a + 1], mem[a]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_preload();
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
  endtask

  task automatic start_cmd(input logic op, input logic [7:0] c, input logic [7:0] f,
                           input logic [7:0] b, input logic hold);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_char  = c;
    bus.cmd_fg    = f;
    bus.cmd_bg    = b;
    @(posedge clk);
    #1;
    bus.cmd_valid = hold;
    bus.cmd_char  = 8'h55;
    bus.cmd_fg    = 8'h55;
    bus.cmd_bg    = 8'h55;
  endtask

  task automatic wait_done(input int start, input int bound, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = start;
    while (!seen && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) cyc = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n              = 1'b0;
    bus.cpu_do_write   = 1'b1;
    bus.cpu_do_byte_op = 1'b1;
    bus.cpu_addr       = 15'd5;
    bus.cpu_write_data = 16'h1234;
    bus.cmd_valid      = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.io_do_write, bus.io_do_byte_op} !== 2'b00) begin
      n_errors++; $display("FAIL reset_io_ctl got %b want 00", {bus.io_do_write, bus.io_do_byte_op});
    end
    n_checks++;
    if ({bus.io_addr, bus.io_write_data} !== 31'd0) begin
      n_errors++; $display("FAIL reset_io_bus got %h/%h want 0/0", bus.io_addr, bus.io_write_data);
    end
    n_checks++;
    if ({bus.busy, bus.done, bus.cpu_stall, bus.cmd_ready} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_status got %b want 0000",
                           {bus.busy, bus.done, bus.cpu_stall, bus.cmd_ready});
    end
    bus.cpu_do_write = 1'b0;
    bus.cpu_do_byte_op = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_release_ready got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_passthrough();
    do_preload();
    @(negedge clk);
    bus.cpu_do_write   = 1'b1;
    bus.cpu_do_byte_op = 1'b1;
    bus.cpu_addr       = 15'd5;
    bus.cpu_write_data = 16'h0041;
    #1;
    n_checks++;
    if ({bus.io_addr, bus.io_do_byte_op, bus.io_do_write, bus.cpu_stall} !== {15'd5, 3'b110}) begin
      n_errors++; $display("FAIL pass_ctl got addr=%0d bo=%b wr=%b stall=%b want 5 1 1 0",
                           bus.io_addr, bus.io_do_byte_op, bus.io_do_write, bus.cpu_stall);
    end
    n_checks++;
    if (bus.io_write_data !== 16'h0041) begin
      n_errors++; $display("FAIL pass_wdata got %h want 0041", bus.io_write_data);
    end
    @(negedge clk);
    bus.cpu_do_write   = 1'b0;
    bus.cpu_do_byte_op = 1'b0;
    bus.cpu_addr       = 15'd8;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (mem[5] !== 8'h41) begin
      n_errors++; $display("FAIL pass_mem5 got %h want 41", mem[5]);
    end
    n_checks++;
    if (bus.cpu_read_data !== 16'd8) begin
      n_errors++; $display("FAIL pass_read got %h want 0008", bus.cpu_read_data);
    end
    bus.cpu_addr = 15'd0;
  endtask

  task automatic test_scroll();
    int cyc;
    int bad0;
    do_preload();
    bad0 = bad_op_cnt;
    start_cmd(1'b0, 8'h20, 8'h07, 8'h00, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.cpu_stall, bus.cmd_ready} !== 3'b110) begin
      n_errors++; $display("FAIL scroll_busy got %b want 110", {bus.busy, bus.cpu_stall, bus.cmd_ready});
    end
    wait_done(1, 20000, cyc);
    n_checks++;
    if (cyc != 10561) begin
      n_errors++; $display("FAIL scroll_latency got %0d want 10561", cyc);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.busy, bus.cmd_ready} !== 3'b001) begin
      n_errors++; $display("FAIL scroll_after got %b want 001", {bus.done, bus.busy, bus.cmd_ready});
    end
    n_checks++;
    if (rdw(0) !== 16'd240 || rdw(2) !== 16'd242) begin
      n_errors++; $display("FAIL scroll_word0 got %0d/%0d want 240/242", rdw(0), rdw(2));
    end
    n_checks++;
    if (rdw(6958) !== 16'd7198) begin
      n_errors++; $display("FAIL scroll_word6958 got %0d want 7198", rdw(6958));
    end
    n_checks++;
    if ({mem[6960], mem[6961], mem[6962]} !== 24'h200700) begin
      n_errors++; $display("FAIL scroll_fill got %h%h%h want 200700", mem[6960], mem[6961], mem[6962]);
    end
    n_checks++;
    if ({mem[7198], mem[7199], mem[7201]} !== 24'h07001C) begin
      n_errors++; $display("FAIL scroll_fill_end got %h%h%h want 07001c", mem[7198], mem[7199], mem[7201]);
    end
    n_checks++;
    if (bad_op_cnt != bad0) begin
      n_errors++; $display("FAIL scroll_word_ops got %0d byte/odd writes want 0", bad_op_cnt - bad0);
    end
  endtask

  task automatic test_clear();
    int cyc;
    int w0;
    do_preload();
    w0 = eng_wr_cnt;
    start_cmd(1'b1, 8'h2E, 8'hFF, 8'h01, 1'b0);
    wait_done(0, 20000, cyc);
    @(negedge clk);
`ifdef VGA_TEXT_CLEAR_EN
    n_checks++;
    if (cyc != 3601) begin
      n_errors++; $display("FAIL clear_latency got %0d want 3601", cyc);
    end
    n_checks++;
    if ({rdw(0), rdw(2), rdw(4)} !== 48'hFF2E_2E01_01FF) begin
      n_errors++; $display("FAIL clear_words got %h %h %h want ff2e 2e01 01ff", rdw(0), rdw(2), rdw(4));
    end
    n_checks++;
    if ({mem[7197], mem[7198], mem[7199]} !== 24'h2EFF01) begin
      n_errors++; $display("FAIL clear_end got %h%h%h want 2eff01", mem[7197], mem[7198], mem[7199]);
    end
    n_checks++;
    if ({mem[7200], mem[7201]} !== 16'h201C) begin
      n_errors++; $display("FAIL clear_beyond got %h%h want 201c", mem[7200], mem[7201]);
    end
`else
    n_checks++;
    if (cyc != 1) begin
      n_errors++; $display("FAIL noclear_latency got %0d want 1", cyc);
    end
    n_checks++;
    if (eng_wr_cnt != w0) begin
      n_errors++; $display("FAIL noclear_writes got %0d want 0", eng_wr_cnt - w0);
    end
    n_checks++;
    if (rdw(0) !== 16'd0 || rdw(4) !== 16'd4) begin
      n_errors++; $display("FAIL noclear_mem got %h/%h want 0000/0004", rdw(0), rdw(4));
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    do_preload();
    start_cmd(1'b0, 8'h20, 8'h07, 8'h00, 1'b0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.cpu_stall, bus.cmd_ready, bus.io_do_write, bus.io_do_byte_op} !== 6'd0) begin
      n_errors++; $display("FAIL midrst_status got %b want 000000",
        {bus.busy, bus.done, bus.cpu_stall, bus.cmd_ready, bus.io_do_write, bus.io_do_byte_op});
    end
    n_checks++;
    if ({bus.io_addr, bus.io_write_data} !== 31'd0) begin
      n_errors++; $display("FAIL midrst_io got %h/%h want 0/0", bus.io_addr, bus.io_write_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_errors++; $display("FAIL midrst_no_done got %b want 0", saw_done);
    end
    n_checks++;
    if ({bus.cmd_ready, bus.busy, dbg_state} !== 5'b10000) begin
      n_errors++; $display("FAIL midrst_idle got ready=%b busy=%b st=%0d want 1 0 0",
                           bus.cmd_ready, bus.busy, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_preload();
    start_cmd(1'b0, 8'h20, 8'h07, 8'h00, 1'b1);
    repeat (4) @(negedge clk);
    bus.cpu_do_write   = 1'b1;
    bus.cpu_do_byte_op = 1'b1;
    bus.cpu_addr       = 15'd7300;
    bus.cpu_write_data = 16'h0099;
    #1;
    n_checks++;
    if ({bus.cpu_stall, bus.cmd_ready} !== 2'b10) begin
      n_errors++; $display("FAIL b2b_stall got %b want 10", {bus.cpu_stall, bus.cmd_ready});
    end
    @(negedge clk);
    bus.cpu_do_write   = 1'b0;
    bus.cpu_do_byte_op = 1'b0;
    bus.cpu_addr       = 15'd0;
    wait_done(5, 20000, cyc);
    n_checks++;
    if (cyc != 10561) begin
      n_errors++; $display("FAIL b2b_first_latency got %0d want 10561", cyc);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
      n_errors++; $display("FAIL b2b_gap got %b want 10", {bus.cmd_ready, bus.busy});
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_errors++; $display("FAIL b2b_second_accept got %b want 1", bus.busy);
    end
    wait_done(1, 20000, cyc);
    n_checks++;
    if (cyc != 10561) begin
      n_errors++; $display("FAIL b2b_second_latency got %0d want 10561", cyc);
    end
    @(negedge clk);
    n_checks++;
    if (mem[7300] !== 8'h84) begin
      n_errors++; $display("FAIL b2b_cpu_blocked got %h want 84", mem[7300]);
    end
    n_checks++;
    if (rdw(0) !== 16'd480 || rdw(6720) !== 16'h0720) begin
      n_errors++; $display("FAIL b2b_double_scroll got %h/%h want 01e0/0720", rdw(0), rdw(6720));
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_checks           = 0;
    n_errors           = 0;
    eng_wr_cnt         = 0;
    bad_op_cnt         = 0;
    preload            = 1'b0;
    bus.cmd_valid      = 1'b0;
    bus.cmd_op         = 1'b0;
    bus.cmd_char       = 8'h00;
    bus.cmd_fg         = 8'h00;
    bus.cmd_bg         = 8'h00;
    bus.cpu_do_write   = 1'b0;
    bus.cpu_do_byte_op = 1'b0;
    bus.cpu_addr       = 15'd0;
    bus.cpu_write_data = 16'd0;
    test_reset();
    test_passthrough();
    test_scroll();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
